// File: rtl/imem_boot_loader.sv
// Boot loader: parses a host byte stream (count header, payload words, XOR checksum)
// into instruction-memory writes and releases the core once the image verifies.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam int          CW        = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [CW-1:0]         widx_q, widx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic        accept;
  logic [31:0] full_word;

  assign rx_ready  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = rx_valid && rx_ready;
  // Bytes shift in from the top so the first byte ends up in bits 7:0.
  assign full_word = {rx_data, asm_q};

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          bidx_d  = '0;
          widx_d  = '0;
          cnt_d   = '0;
          asm_d   = '0;
          csum_d  = '0;
        end
      end
      S_HDR: begin
        if (accept) begin
          bidx_d = bidx_q + 2'd1;
          asm_d  = {rx_data, asm_q[23:8]};
          if (bidx_q == 2'd3) begin
            if ((full_word == 32'd0) || (full_word > MAX_WORDS)) begin
              state_d = S_ERR;
            end else begin
              cnt_d   = full_word[CW-1:0];
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          bidx_d = bidx_q + 2'd1;
          asm_d  = {rx_data, asm_q[23:8]};
          csum_d = csum_q ^ rx_data;
          if (bidx_q == 2'd3) begin
            // Write is registered: it appears on the cycle after the 4th byte.
            we_d    = 1'b1;
            addr_d  = ADDR_WIDTH'(BASE_ADDR) + widx_q[ADDR_WIDTH-1:0];
            wdata_d = full_word;
            widx_d  = widx_q + CW'(1);
            if (widx_q == cnt_q - CW'(1)) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bidx_q  <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign core_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued as the
// image is sent and checked by a monitor when imem_we fires.
module tb_imem_boot_loader;
  localparam int AW   = 10;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, imem_we, core_hold, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] img[4];
  int          cyc = 0;
  int          last_we_cyc = 0;
  bit          have_last = 1'b0;
  bit          tp_on = 1'b0;
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (imem_we) begin
        chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
        n_cmp++;
        assert (exp_addr.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_we observed addr=%h data=%h expected no write", imem_addr, imem_wdata);
        end
        if (exp_addr.size() != 0) begin
          chk("we_addr", 32'(imem_addr), exp_addr.pop_front());
          chk("we_data", imem_wdata, exp_data.pop_front());
        end
        if (tp_on && have_last) chk("we_spacing", 32'(cyc - last_we_cyc), 32'd4);
        last_we_cyc = cyc;
        have_last   = 1'b1;
      end
      prev_we = imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    start    = 1'b0;
    tp_on    = 1'b0;
    have_last = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] n, input int gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
  endtask

  // Sends header, img[0..n-1] and the XOR checksum (optionally corrupted).
  task automatic send_image(input int n, input bit corrupt, input int gap);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    send_hdr(32'(n), gap);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_addr.push_back(32'((BASE + i) % (1 << AW)));
      exp_data.push_back(w);
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], gap);
      end
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs, gap);
  endtask

  task automatic expect_status(input string tag, input logic d, input logic e, input logic h);
    @(negedge clk);
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".error"}, {31'd0, error}, {31'd0, e});
    chk({tag, ".core_hold"}, {31'd0, core_hold}, {31'd0, h});
  endtask

  initial begin
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'h0;
    img[3] = 32'h0;

    // Reset values, while rst is still high.
    #2;
    chk("rst.core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst.rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst.imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst.done_error", {30'd0, done, error}, 32'd0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk("rst.wdata", imem_wdata, 32'd0);
    do_reset();

    // rx_valid in IDLE is ignored.
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("idle.rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("idle.hold", {30'd0, core_hold, error}, 32'd2);
    end
    rx_valid = 1'b0;
    step();

    // Normal load; checksum of the payload is 0x90.
    pulse_start();
    send_image(2, 1'b0, 0);
    expect_status("normal", 1'b1, 1'b0, 1'b0);
    chk("normal.q_empty", 32'(exp_addr.size()), 32'd0);
    start = 1'b1; rx_valid = 1'b1;
    repeat (2) step();
    start = 1'b0; rx_valid = 1'b0;
    expect_status("done_terminal", 1'b1, 1'b0, 1'b0);

    // Reset clears the write port registers.
    rst = 1'b1; #1;
    chk("rst2.wdata", imem_wdata, 32'd0);
    chk("rst2.core_hold", {31'd0, core_hold}, 32'd1);
    do_reset();

    // Bad checksum, then retry from ERR.
    pulse_start();
    send_image(2, 1'b1, 0);
    expect_status("badcs", 1'b0, 1'b1, 1'b1);
    step();
    pulse_start();
    @(negedge clk);
    chk("retry.rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("retry.error", {31'd0, error}, 32'd0);
    step();
    send_image(2, 1'b0, 0);
    expect_status("retry", 1'b1, 1'b0, 1'b0);
    chk("retry.q_empty", 32'(exp_addr.size()), 32'd0);
    do_reset();

    // Header limits.
    pulse_start();
    send_hdr(32'd0, 0);
    expect_status("hdr0", 1'b0, 1'b1, 1'b1);
    step();
    pulse_start();
    send_hdr(32'd1025, 0);
    expect_status("hdr1025", 1'b0, 1'b1, 1'b1);
    step();
    pulse_start();
    send_hdr(32'd1024, 0);
    @(negedge clk);
    chk("hdr1024.rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("hdr1024.error", {31'd0, error}, 32'd0);
    do_reset();

    // Flow control: a byte every third cycle.
    pulse_start();
    send_image(2, 1'b0, 2);
    expect_status("flow", 1'b1, 1'b0, 1'b0);
    chk("flow.q_empty", 32'(exp_addr.size()), 32'd0);
    do_reset();

    // Reset mid-load after the 6th byte, between edges.
    pulse_start();
    send_hdr(32'd2, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.core_hold", {31'd0, core_hold}, 32'd1);
    chk("midrst.rx_ready", {31'd0, rx_ready}, 32'd0);
    step(); step();
    rst = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("midrst.idle_ready", {31'd0, rx_ready}, 32'd0);
      chk("midrst.idle_hold", {29'd0, core_hold, done, error}, 32'd4);
    end
    rx_valid = 1'b0;
    step();
    chk("midrst.q_empty", 32'(exp_addr.size()), 32'd0);
    do_reset();

    // Throughput: four words back to back.
    img[0] = 32'h0403_0201;
    img[1] = 32'h0807_0605;
    img[2] = 32'h0C0B_0A09;
    img[3] = 32'h100F_0E0D;
    tp_on = 1'b1;
    pulse_start();
    send_image(4, 1'b0, 0);
    expect_status("tput", 1'b1, 1'b0, 1'b0);
    chk("tput.q_empty", 32'(exp_addr.size()), 32'd0);
    tp_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
